hard_mem_1rw_arb_ctrl: RTL and testbench



---
 rtl/hard_mem_1rw_arb_ctrl.sv | 118 +++++++++++
 tb/tb_hard_mem_1rw_arb_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/hard_mem_1rw_arb_ctrl.sv
// Shares one 1RW byte-masked SRAM macro between two requesters. After reset it can
// zero-fill the array, then it grants one port per cycle round-robin and returns read data one cycle later.
module hard_mem_1rw_arb_ctrl #(
    parameter int els_p         = 512,
    parameter int width_p       = 64,
    parameter bit init_zero_p   = 1'b1,
    parameter int addr_width_lp = $clog2(els_p),
    parameter int mask_width_lp = width_p / 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [1:0]                 req_v_i,
    input  logic [1:0]                 req_w_i,
    input  logic [2*addr_width_lp-1:0] req_addr_i,
    input  logic [2*width_p-1:0]       req_data_i,
    input  logic [2*mask_width_lp-1:0] req_mask_i,
    output logic [1:0]                 req_ready_o,
    output logic [1:0]                 resp_v_o,
    output logic [width_p-1:0]         resp_data_o,
    output logic                       init_done_o,
    output logic                       mem_v_o,
    output logic                       mem_w_o,
    output logic [addr_width_lp-1:0]   mem_addr_o,
    output logic [width_p-1:0]         mem_data_o,
    output logic [width_p-1:0]         mem_w_mask_o,
    input  logic [width_p-1:0]         mem_data_i
);

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

    localparam logic [addr_width_lp-1:0] last_addr = addr_width_lp'(els_p - 1);

    state_t                     state_r, state_n;
    logic [addr_width_lp-1:0]   cnt_r, cnt_n;
    logic                       prio_r;
    logic [1:0]                 resp_v_r;
    logic [1:0]                 grant;
    logic [1:0][width_p-1:0]    bit_mask;

    // Byte-mask to bit-mask expansion for both ports.
    for (genvar p = 0; p < 2; p++) begin : g_port
        for (genvar b = 0; b < mask_width_lp; b++) begin : g_byte
            assign bit_mask[p][b*8 +: 8] = {8{req_mask_i[p*mask_width_lp + b]}};
        end
    end

    // Grants are suppressed while reset is held so the handshake never completes under reset.
    always_comb begin
        grant = 2'b00;
        if (state_r == RUN && !reset_i) begin
            if (&req_v_i) begin
                grant[prio_r] = 1'b1;
            end else begin
                grant = req_v_i;
            end
        end
    end

    assign req_ready_o = grant;

    always_comb begin
        state_n      = state_r;
        cnt_n        = cnt_r;
        mem_v_o      = 1'b0;
        mem_w_o      = 1'b0;
        mem_addr_o   = cnt_r;
        mem_data_o   = '0;
        mem_w_mask_o = '1;
        case (state_r)
            INIT: begin
                mem_v_o = !reset_i;
                mem_w_o = !reset_i;
                cnt_n   = cnt_r + 1'b1;
                if (cnt_r == last_addr) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (grant[1]) begin
                    mem_v_o      = 1'b1;
                    mem_w_o      = req_w_i[1];
                    mem_addr_o   = req_addr_i[addr_width_lp +: addr_width_lp];
                    mem_data_o   = req_data_i[width_p +: width_p];
                    mem_w_mask_o = req_w_i[1] ? bit_mask[1] : '0;
                end else if (grant[0]) begin
                    mem_v_o      = 1'b1;
                    mem_w_o      = req_w_i[0];
                    mem_addr_o   = req_addr_i[0 +: addr_width_lp];
                    mem_data_o   = req_data_i[0 +: width_p];
                    mem_w_mask_o = req_w_i[0] ? bit_mask[0] : '0;
                end
            end
            default: state_n = RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r  <= init_zero_p ? INIT : RUN;
            cnt_r    <= '0;
            prio_r   <= 1'b0;
            resp_v_r <= 2'b00;
        end else begin
            state_r  <= state_n;
            cnt_r    <= cnt_n;
            resp_v_r <= grant & ~req_w_i;
            // Only contended cycles move the pointer, away from the port just served.
            if (&req_v_i && |grant) begin
                prio_r <= ~grant[1];
            end
        end
    end

    assign resp_v_o    = resp_v_r;
    assign resp_data_o = mem_data_i;
    assign init_done_o = (state_r == RUN);

endmodule

// File: tb/tb_hard_mem_1rw_arb_ctrl.sv
// Directed bench for hard_mem_1rw_arb_ctrl with a behavioural 1RW macro and a read-response scoreboard.
module tb_hard_mem_1rw_arb_ctrl;

    localparam int AW = 9;
    localparam int W  = 64;
    localparam int MW = 8;

    logic            clk = 1'b0;
    logic            reset_i;
    logic [1:0]      req_v_i, req_w_i;
    logic [2*AW-1:0] req_addr_i;
    logic [2*W-1:0]  req_data_i;
    logic [2*MW-1:0] req_mask_i;
    logic [1:0]      req_ready_o, resp_v_o;
    logic [W-1:0]    resp_data_o;
    logic            init_done_o, mem_v_o, mem_w_o;
    logic [AW-1:0]   mem_addr_o;
    logic [W-1:0]    mem_data_o, mem_w_mask_o, mem_data_i;

    hard_mem_1rw_arb_ctrl dut (
        .clk_i(clk), .reset_i(reset_i),
        .req_v_i(req_v_i), .req_w_i(req_w_i), .req_addr_i(req_addr_i),
        .req_data_i(req_data_i), .req_mask_i(req_mask_i), .req_ready_o(req_ready_o),
        .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .init_done_o(init_done_o),
        .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_w_mask_o(mem_w_mask_o), .mem_data_i(mem_data_i)
    );

    always #5 clk = ~clk;

    // Behavioural macro, preloaded with garbage so the zero-fill is observable.
    logic [W-1:0] macro_mem [512];
    logic [W-1:0] rd_q = '0;
    initial for (int i = 0; i < 512; i++) macro_mem[i] = {32'hA5A5_0000 + i, 32'h5A5A_FFFF ^ i};
    always @(posedge clk) begin
        if (mem_v_o) begin
            if (mem_w_o) macro_mem[mem_addr_o] <= (macro_mem[mem_addr_o] & ~mem_w_mask_o) | (mem_data_o & mem_w_mask_o);
            else         rd_q <= macro_mem[mem_addr_o];
        end
    end
    assign mem_data_i = rd_q;

    typedef struct packed {logic [1:0] v; logic [W-1:0] d;} resp_t;
    resp_t        sb[$];
    logic [W-1:0] exp_mem [512];
    int           vectors = 0;
    int           miscompares = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] expand(input logic [MW-1:0] m);
        logic [W-1:0] r;
        for (int b = 0; b < MW; b++) r[b*8 +: 8] = {8{m[b]}};
        return r;
    endfunction

    task automatic check_resp(input string tag);
        resp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({"resp_", tag}, {resp_v_o, resp_data_o}, {e.v, e.d});
        end else begin
            chk({"noresp_", tag}, resp_v_o, 2'b00);
        end
    endtask

    task automatic sweep(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            chk($sformatf("init_%0d", i),
                {mem_v_o, mem_w_o, req_ready_o, resp_v_o, init_done_o, mem_addr_o, mem_data_o, mem_w_mask_o},
                {1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 9'(i), 64'h0, {64{1'b1}}});
            @(negedge clk);
        end
    endtask

    task automatic step(input string tag, input logic [1:0] v, input logic [1:0] w,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [W-1:0] d0, input logic [W-1:0] d1,
                        input logic [MW-1:0] m0, input logic [MW-1:0] m1, input logic [1:0] eg);
        logic [AW-1:0] a;
        logic [W-1:0]  d, bm;
        logic          wr;
        @(negedge clk);
        check_resp(tag);
        req_v_i = v; req_w_i = w;
        req_addr_i = {a1, a0}; req_data_i = {d1, d0}; req_mask_i = {m1, m0};
        #1;
        chk({"grant_", tag}, req_ready_o, eg);
        if (eg != 2'b00) begin
            a  = eg[1] ? a1 : a0;
            d  = eg[1] ? d1 : d0;
            wr = eg[1] ? w[1] : w[0];
            bm = wr ? expand(eg[1] ? m1 : m0) : '0;
            chk({"pins_", tag}, {mem_v_o, mem_w_o, mem_addr_o, wr ? mem_data_o : 64'h0, mem_w_mask_o},
                {1'b1, wr, a, wr ? d : 64'h0, bm});
            if (wr) exp_mem[a] = (exp_mem[a] & ~bm) | (d & bm);
            else    sb.push_back({eg, exp_mem[a]});
        end else begin
            chk({"idle_", tag}, mem_v_o, 1'b0);
        end
    endtask

    initial begin
        reset_i = 1'b1;
        req_v_i = 2'b11; req_w_i = 2'b00; req_addr_i = '0; req_data_i = '0; req_mask_i = '0;
        repeat (3) @(negedge clk);
        #1 chk("reset", {req_ready_o, resp_v_o, init_done_o, mem_v_o, mem_w_o}, 7'b0);
        @(negedge clk);
        reset_i = 1'b0;
        // Interrupted sweep, then a full one from address 0.
        sweep(100);
        reset_i = 1'b1;
        #1 chk("reset_mid_init", {req_ready_o, mem_v_o, mem_w_o}, 4'b0);
        @(negedge clk);
        reset_i = 1'b0;
        sweep(512);
        req_v_i = 2'b00;
        #1 chk("init_done", {init_done_o, req_ready_o, mem_v_o}, 4'b1000);
        for (int i = 0; i < 512; i++) exp_mem[i] = '0;

        // Full write then cross-port read.
        step("wr5",   2'b01, 2'b01, 9'd5, 9'd0, 64'hDEADBEEF_01234567, 64'h0, 8'hFF, 8'h00, 2'b01);
        step("rd5_p1", 2'b10, 2'b00, 9'd0, 9'd5, 64'h0, 64'h0, 8'h00, 8'h00, 2'b10);
        // Partial write over zero-filled word.
        step("wr7",   2'b01, 2'b01, 9'd7, 9'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 8'h0F, 8'h00, 2'b01);
        step("rd7_p0", 2'b01, 2'b00, 9'd7, 9'd0, 64'h0, 64'h0, 8'h00, 8'h00, 2'b01);
        step("flush0", 2'b00, 2'b00, 9'd0, 9'd0, 64'h0, 64'h0, 8'h00, 8'h00, 2'b00);
        vectors++;
        assert (exp_mem[7] === 64'h00000000_FFFFFFFF) else begin
            miscompares++;
            $error("FAIL partial_model observed=%0h expected=%0h", exp_mem[7], 64'h00000000_FFFFFFFF);
        end
        // Contended reads alternate starting with port 0.
        step("rr0", 2'b11, 2'b00, 9'd5, 9'd7, 64'h0, 64'h0, 8'h00, 8'h00, 2'b01);
        step("rr1", 2'b11, 2'b00, 9'd5, 9'd7, 64'h0, 64'h0, 8'h00, 8'h00, 2'b10);
        step("rr2", 2'b11, 2'b00, 9'd7, 9'd5, 64'h0, 64'h0, 8'h00, 8'h00, 2'b01);
        step("rr3", 2'b11, 2'b00, 9'd7, 9'd5, 64'h0, 64'h0, 8'h00, 8'h00, 2'b10);
        // Uncontended port 1 leaves the pointer at port 0.
        step("p1a", 2'b10, 2'b00, 9'd0, 9'd5, 64'h0, 64'h0, 8'h00, 8'h00, 2'b10);
        step("p1b", 2'b10, 2'b00, 9'd0, 9'd7, 64'h0, 64'h0, 8'h00, 8'h00, 2'b10);
        step("p1c", 2'b10, 2'b00, 9'd0, 9'd9, 64'h0, 64'h0, 8'h00, 8'h00, 2'b10);
        step("ct0", 2'b11, 2'b00, 9'd5, 9'd7, 64'h0, 64'h0, 8'h00, 8'h00, 2'b01);
        // Mixed write/read contention; port 1 write lands at the top address.
        step("ct1", 2'b11, 2'b10, 9'd5, 9'd511, 64'h0, 64'h1122334455667788, 8'h00, 8'hA5, 2'b10);
        step("rd511", 2'b01, 2'b00, 9'd511, 9'd0, 64'h0, 64'h0, 8'h00, 8'h00, 2'b01);
        step("rd_p1_9", 2'b10, 2'b00, 9'd0, 9'd9, 64'h0, 64'h0, 8'h00, 8'h00, 2'b10);
        step("flush1", 2'b00, 2'b00, 9'd0, 9'd0, 64'h0, 64'h0, 8'h00, 8'h00, 2'b00);

        // Reset from RUN returns to the sweep with everything quiet.
        @(negedge clk);
        reset_i = 1'b1; req_v_i = 2'b11;
        @(negedge clk);
        #1 chk("reset_run", {init_done_o, req_ready_o, resp_v_o, mem_v_o}, 6'b0);
        reset_i = 1'b0;
        @(negedge clk);
        #1 chk("resweep0", {mem_v_o, mem_w_o, mem_addr_o, req_ready_o}, {2'b11, 9'd1, 2'b00});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
